// File: rtl/tgt_ddr_rd_seq_if.sv
// Bundles the engine, serializer and register-file signals of the HDR-DDR
// read-response sequencer. The master side is the engine/serializer
// environment and the slave side is the sequencer itself.
interface tgt_ddr_rd_seq_if #(
  parameter int WC_W   = 8,
  parameter int ADDR_W = 12
);
  logic              i_engine_start;
  logic [WC_W-1:0]   i_engine_word_cnt;
  logic [ADDR_W-1:0] i_engine_base_addr;
  logic              i_engine_abort;
  logic              i_tx_mode_done;
  logic              o_tx_en;
  logic [2:0]        o_tx_mode;
  logic              o_regf_rd_en;
  logic [ADDR_W-1:0] o_regf_addr;
  logic              o_engine_busy;
  logic              o_engine_done;
  logic              o_engine_aborted;

  modport master (
    output i_engine_start, i_engine_word_cnt, i_engine_base_addr,
           i_engine_abort, i_tx_mode_done,
    input  o_tx_en, o_tx_mode, o_regf_rd_en, o_regf_addr,
           o_engine_busy, o_engine_done, o_engine_aborted
  );

  modport slave (
    input  i_engine_start, i_engine_word_cnt, i_engine_base_addr,
           i_engine_abort, i_tx_mode_done,
    output o_tx_en, o_tx_mode, o_regf_rd_en, o_regf_addr,
           o_engine_busy, o_engine_done, o_engine_aborted
  );
endinterface

// File: rtl/tgt_ddr_rd_seq.sv
// Target-side HDR-DDR read-response sequencer: walks tx_t through
// preamble/byte/byte/parity per data word, then the CRC preamble, token and
// value, fetching bytes from the register file with an incrementing address.
module tgt_ddr_rd_seq #(
  parameter int WC_W   = 8,
  parameter int ADDR_W = 12
) (
  input  logic           i_sys_clk,
  input  logic           i_sys_rst,
  tgt_ddr_rd_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, W_PRE1, W_PRE0, BYTE_HI, BYTE_LO, PARITY,
    C_PRE0, C_PRE1, C_TOKEN, C_VALUE
  } state_e;

  typedef enum logic [2:0] {
    M_PRE0  = 3'b000,
    M_PRE1  = 3'b001,
    M_TOKEN = 3'b010,
    M_BYTE  = 3'b011,
    M_PAR   = 3'b110,
    M_CRCV  = 3'b111
  } mode_e;

  localparam logic [WC_W-1:0]   REM_ONE  = WC_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              abort_q, abort_d;
  logic              abort_eff;
  logic              done_d, aborted_d, rd_en_d;
  logic              tx_en_q, rd_en_q, busy_q, done_q, aborted_q;
  mode_e             mode_q;

  function automatic mode_e mode_of(input state_e s);
    case (s)
      W_PRE1, C_PRE1:   mode_of = M_PRE1;
      BYTE_HI, BYTE_LO: mode_of = M_BYTE;
      PARITY:           mode_of = M_PAR;
      C_TOKEN:          mode_of = M_TOKEN;
      C_VALUE:          mode_of = M_CRCV;
      default:          mode_of = M_PRE0;
    endcase
  endfunction

  // Next-state, counter, address and abort-latch computation.
  // An abort arriving with the same done is folded in so that done completes it.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    abort_eff = abort_q | bus.i_engine_abort;
    if (state_q == IDLE) begin
      if (bus.i_engine_start) begin
        rem_d   = bus.i_engine_word_cnt;
        addr_d  = bus.i_engine_base_addr;
        abort_d = 1'b0;
        state_d = (bus.i_engine_word_cnt != '0) ? W_PRE1 : C_PRE0;
      end
    end else begin
      if (bus.i_engine_abort) abort_d = 1'b1;
      if (bus.i_tx_mode_done) begin
        case (state_q)
          W_PRE1:  state_d = W_PRE0;
          W_PRE0:  state_d = BYTE_HI;
          BYTE_HI: begin state_d = BYTE_LO; addr_d = addr_q + ADDR_ONE; end
          BYTE_LO: begin state_d = PARITY;  addr_d = addr_q + ADDR_ONE; end
          PARITY: begin
            rem_d   = rem_q - REM_ONE;
            state_d = (rem_q == REM_ONE) ? C_PRE0 : W_PRE1;
          end
          C_PRE0:  state_d = C_PRE1;
          C_PRE1:  state_d = C_TOKEN;
          C_TOKEN: state_d = C_VALUE;
          C_VALUE: begin state_d = IDLE; done_d = 1'b1; end
          default: state_d = IDLE;
        endcase
        if (abort_eff && state_q inside {W_PRE1, W_PRE0, BYTE_HI, BYTE_LO, PARITY}) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end
      end
    end
    rd_en_d = (state_d != state_q) && (state_d inside {BYTE_HI, BYTE_LO});
  end

  // State and all registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      addr_q    <= '0;
      abort_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      mode_q    <= M_PRE0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      abort_q   <= abort_d;
      tx_en_q   <= (state_d != IDLE);
      mode_q    <= mode_of(state_d);
      rd_en_q   <= rd_en_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.o_tx_en          = tx_en_q;
  assign bus.o_tx_mode        = mode_q;
  assign bus.o_regf_rd_en     = rd_en_q;
  assign bus.o_regf_addr      = addr_q;
  assign bus.o_engine_busy    = busy_q;
  assign bus.o_engine_done    = done_q;
  assign bus.o_engine_aborted = aborted_q;

endmodule

// File: tb/tb_tgt_ddr_rd_seq.sv
// Directed bench for tgt_ddr_rd_seq with hand-computed mode/address sequences.
module tb_tgt_ddr_rd_seq;

  localparam int WC_W   = 8;
  localparam int ADDR_W = 12;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tgt_ddr_rd_seq_if #(.WC_W(WC_W), .ADDR_W(ADDR_W)) bus ();

  tgt_ddr_rd_seq #(.WC_W(WC_W), .ADDR_W(ADDR_W)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check idle-level outputs (done/aborted pulses checked separately).
  task automatic chk_idle(input string tag);
    chk({tag, "_en"},   32'(bus.o_tx_en), 32'h0);
    chk({tag, "_mode"}, 32'(bus.o_tx_mode), 32'h0);
    chk({tag, "_busy"}, 32'(bus.o_engine_busy), 32'h0);
    chk({tag, "_rd"},   32'(bus.o_regf_rd_en), 32'h0);
  endtask

  // Called at the first cycle of a segment: verify it, hold for 8 cycles, then done.
  task automatic seg(input string tag, input logic [2:0] mode, input bit rd,
                     input logic [ADDR_W-1:0] addr, input bit ab);
    chk({tag, "_mode"}, 32'(bus.o_tx_mode), 32'(mode));
    chk({tag, "_en"},   32'(bus.o_tx_en), 32'h1);
    chk({tag, "_busy"}, 32'(bus.o_engine_busy), 32'h1);
    chk({tag, "_rd"},   32'(bus.o_regf_rd_en), 32'(rd));
    if (rd) chk({tag, "_addr"}, 32'(bus.o_regf_addr), 32'(addr));
    tick();
    chk({tag, "_rd1"}, 32'(bus.o_regf_rd_en), 32'h0);
    if (ab) bus.i_engine_abort = 1'b1;
    tick();
    bus.i_engine_abort = 1'b0;
    repeat (5) tick();
    chk({tag, "_hold"}, 32'(bus.o_tx_mode), 32'(mode));
    bus.i_tx_mode_done = 1'b1;
    tick();
    bus.i_tx_mode_done = 1'b0;
  endtask

  task automatic start(input logic [WC_W-1:0] cnt, input logic [ADDR_W-1:0] base);
    bus.i_engine_word_cnt  = cnt;
    bus.i_engine_base_addr = base;
    bus.i_engine_start     = 1'b1;
    tick();
    bus.i_engine_start     = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1;
    a1 = a + ADDR_W'(1);
    seg({tag, "_p1"}, 3'b001, 1'b0, '0, 1'b0);
    seg({tag, "_p0"}, 3'b000, 1'b0, '0, 1'b0);
    seg({tag, "_hi"}, 3'b011, 1'b1, a,  1'b0);
    seg({tag, "_lo"}, 3'b011, 1'b1, a1, 1'b0);
    seg({tag, "_par"}, 3'b110, 1'b0, '0, 1'b0);
  endtask

  task automatic run_crc(input string tag, input bit ab_token);
    seg({tag, "_c0"},  3'b000, 1'b0, '0, 1'b0);
    seg({tag, "_c1"},  3'b001, 1'b0, '0, 1'b0);
    seg({tag, "_tok"}, 3'b010, 1'b0, '0, ab_token);
    seg({tag, "_val"}, 3'b111, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_end(input string tag, input bit exp_done, input bit exp_abt);
    chk_idle(tag);
    chk({tag, "_done"}, 32'(bus.o_engine_done), 32'(exp_done));
    chk({tag, "_abt"},  32'(bus.o_engine_aborted), 32'(exp_abt));
    tick();
    chk({tag, "_done2"}, 32'(bus.o_engine_done), 32'h0);
    chk({tag, "_abt2"},  32'(bus.o_engine_aborted), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.i_engine_start     = 1'b0;
    bus.i_engine_word_cnt  = '0;
    bus.i_engine_base_addr = '0;
    bus.i_engine_abort     = 1'b0;
    bus.i_tx_mode_done     = 1'b0;
    repeat (2) tick();

    // Reset state
    chk_idle("rst");
    chk("rst_addr", 32'(bus.o_regf_addr), 32'h0);
    chk("rst_done", 32'(bus.o_engine_done), 32'h0);
    chk("rst_abt",  32'(bus.o_engine_aborted), 32'h0);
    rst_n = 1'b1;
    tick();

    // One word from 0x010
    start(8'd1, 12'h010);
    run_word("w1", 12'h010);
    run_crc("w1", 1'b0);
    chk_end("w1_end", 1'b1, 1'b0);

    // CRC only
    start(8'd0, 12'h123);
    run_crc("w0", 1'b0);
    chk_end("w0_end", 1'b1, 1'b0);

    // Three words with address wrap
    start(8'd3, 12'hFFE);
    run_word("w3a", 12'hFFE);
    run_word("w3b", 12'h000);
    run_word("w3c", 12'h002);
    run_crc("w3", 1'b0);
    chk_end("w3_end", 1'b1, 1'b0);

    // Abort pulse during first BYTE_LO, completes at the next done
    start(8'd2, 12'h040);
    seg("ab_p1", 3'b001, 1'b0, '0, 1'b0);
    seg("ab_p0", 3'b000, 1'b0, '0, 1'b0);
    seg("ab_hi", 3'b011, 1'b1, 12'h040, 1'b0);
    seg("ab_lo", 3'b011, 1'b1, 12'h041, 1'b1);
    chk_end("ab_end", 1'b0, 1'b1);

    // Abort during C_TOKEN is ignored
    start(8'd0, 12'h000);
    run_crc("abc", 1'b1);
    chk_end("abc_end", 1'b1, 1'b0);

    // Abort in the same cycle as done in W_PRE1
    start(8'd1, 12'h050);
    chk("sc_mode", 32'(bus.o_tx_mode), 32'h1);
    bus.i_engine_abort = 1'b1;
    bus.i_tx_mode_done = 1'b1;
    tick();
    bus.i_engine_abort = 1'b0;
    bus.i_tx_mode_done = 1'b0;
    chk_end("sc_end", 1'b0, 1'b1);

    // Second start while busy is ignored
    start(8'd1, 12'h060);
    start(8'd0, 12'h300);
    chk("bs_mode", 32'(bus.o_tx_mode), 32'h1);
    chk("bs_busy", 32'(bus.o_engine_busy), 32'h1);
    seg("bs_p1", 3'b001, 1'b0, '0, 1'b0);
    chk("bs_p0", 32'(bus.o_tx_mode), 32'h0);
    chk("bs_en", 32'(bus.o_tx_en), 32'h1);

    // Asynchronous reset during W_PRE0
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("ar");
    chk("ar_addr", 32'(bus.o_regf_addr), 32'h0);
    chk("ar_done", 32'(bus.o_engine_done), 32'h0);
    chk("ar_abt",  32'(bus.o_engine_aborted), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Stray done in IDLE is ignored
    bus.i_tx_mode_done = 1'b1;
    tick();
    bus.i_tx_mode_done = 1'b0;
    chk_idle("sd");
    tick();
    chk_idle("sd2");

    // Clean run after reset
    start(8'd1, 12'h020);
    run_word("cl", 12'h020);
    run_crc("cl", 1'b0);
    chk_end("cl_end", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tgt_ddr_rd_seq.md
# tgt_ddr_rd_seq

Target-side HDR-DDR read-response sequencer. It drives the mode/enable handshake of the target TX serializer `tx_t`. For each 16-bit data word it steps the serializer through preamble, two bytes and parity. It finishes with the CRC preamble, token and value. It also issues byte-fetch requests with an auto-incrementing address to the register file, and it sits between the target DDR engine and `tx_t`.

## Interface
Parameters:
- WC_W, 8, width of word count (max 2^WC_W−1 words)
- ADDR_W, 12, register-file byte address width

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst  in  1  asynchronous, active-low reset
- i_engine_start  in  1  one-cycle start pulse, sampled only in IDLE
- i_engine_word_cnt  in  WC_W  number of data words, sampled with start; 0 = CRC only
- i_engine_base_addr  in  ADDR_W  first byte address, sampled with start
- i_engine_abort  in  1  controller abort request (level or pulse)
- i_tx_mode_done  in  1  one-cycle pulse from `tx_t`: current mode finished
- o_tx_en  out  1  serializer enable
- o_tx_mode  out  3  serializer mode: PREAMBLE_ZERO=000, PREAMBLE_ONE=001, SERIALIZING_BYTE=011, CRC_TOKEN=010, PAR_VALUE=110, CRC_VALUE=111
- o_regf_rd_en  out  1  one-cycle byte-fetch strobe
- o_regf_addr  out  ADDR_W  byte address for fetch
- o_engine_busy  out  1  high whenever not IDLE
- o_engine_done  out  1  one-cycle pulse on normal completion
- o_engine_aborted  out  1  one-cycle pulse on abort completion

## Operation
States and the mode each one drives:
- IDLE: no mode driven.
- W_PRE1: PREAMBLE_ONE.
- W_PRE0: PREAMBLE_ZERO.
- BYTE_HI: SERIALIZING_BYTE.
- BYTE_LO: SERIALIZING_BYTE.
- PARITY: PAR_VALUE.
- C_PRE0: PREAMBLE_ZERO.
- C_PRE1: PREAMBLE_ONE.
- C_TOKEN: CRC_TOKEN.
- C_VALUE: CRC_VALUE.

Transitions:
- IDLE + start: load remaining count, load address, clear abort latch.
  - Go to W_PRE1 if count ≠ 0.
  - Go to C_PRE0 if count = 0.
- Every non-IDLE state advances only on i_tx_mode_done.
  - W_PRE1 → W_PRE0 → BYTE_HI → BYTE_LO → PARITY.
  - PARITY: remaining−1; if the result is 0, go to C_PRE0, else go to W_PRE1.
  - C_PRE0 → C_PRE1 → C_TOKEN → C_VALUE → IDLE, with o_engine_done pulse.

Abort:
- i_engine_abort high in any non-IDLE state sets a sticky latch.
- At the next i_tx_mode_done in a word state (W_PRE1…PARITY), go to IDLE and pulse o_engine_aborted. No CRC is sent.
- In CRC states (C_PRE0…C_VALUE) the latch is ignored and the sequence completes normally.
- Abort in IDLE is ignored. The latch clears on start.

Fetch and address:
- o_regf_rd_en pulses on the first cycle of BYTE_HI and of BYTE_LO.
- o_regf_addr increments by 1 on i_tx_mode_done in BYTE_HI or BYTE_LO.
- The address wraps modulo 2^ADDR_W.

Output behaviour:
- o_tx_en is 1 in every non-IDLE state and 0 in IDLE.
- i_tx_mode_done in IDLE is ignored.
- i_engine_start while busy is ignored.

## Timing
- All outputs are registered.
- Reset values: o_tx_en=0, o_tx_mode=000, o_regf_rd_en=0, o_regf_addr=0, o_engine_busy=0, o_engine_done=0, o_engine_aborted=0. The state is IDLE and the counter and latch are 0.
- Start at cycle t: at t+1, o_tx_en=1, o_engine_busy=1 and o_tx_mode shows the first state's mode.
- Done at cycle t: o_tx_mode shows the next mode at t+1. o_tx_en stays 1 across segment boundaries with no gap.
- Final done (C_VALUE) at cycle t: at t+1, o_tx_en=0, o_tx_mode=000, o_engine_busy=0 and o_engine_done=1 for exactly one cycle.
- Abort completion follows the same timing, with o_engine_aborted in place of o_engine_done.
- Abort and done in the same cycle: the abort is latched first, so that done completes the abort.
- o_regf_rd_en is at t+1 relative to the done or start that enters a byte state. o_regf_addr is already valid in that cycle.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously). There is no completion pulse.

## Test plan
- word_cnt=1, base=0x010, done pulses every 8 cycles:
  - Modes are 001,000,011,011,110,000,001,010,111.
  - rd_en pulses at addresses 0x010 then 0x011.
  - o_engine_done pulses once and o_tx_en falls the same cycle.
- word_cnt=0: modes are 000,001,010,111 only. No rd_en. The done pulse follows.
- word_cnt=3, base=0xFFE: 6 rd_en pulses at addresses 0xFFE,0xFFF,0x000,0x001,0x002,0x003. There are 3 PAR_VALUE segments and then the CRC segments.
- word_cnt=2, abort pulse during the first BYTE_LO:
  - At the next done, the block goes to IDLE and o_engine_aborted=1 for one cycle.
  - No 010 or 111 mode appears.
- Abort during C_TOKEN: the sequence completes through CRC_VALUE and o_engine_done pulses. No aborted pulse occurs.
- Second start while busy, stray done while IDLE, and reset asserted during W_PRE0:
  - The second start and the stray done cause no state change.
  - The reset clears all outputs to their reset values immediately.
  - A following start runs a clean sequence.
